clause_loader: RTL and testbench

- Upstream feeder of the clause/unit-clause distribution stage.
- On `go`, streams N clauses from the clause memory, then M initial unit clauses from the UC memory, onto the `mem2carb_*` interface. It then pulses `mem2carb_finish` to start solving, waits for `carb_empty`, and reports `done`.
- Sits between the host-loaded problem memories and the distribution unit. It is the sole driver of all `mem2carb_*` signals.

---
 rtl/clause_loader.sv | 138 +++++++++++++
 tb/tb_clause_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_loader.sv
// Clause loader: streams N clauses then M unit clauses from the problem memories
// onto the mem2carb interface, pulses finish, then waits for the distributor to drain.

package clause_loader_pkg;
  localparam int LIT_W    = 16;
  localparam int CLA_LITS = 3;
  typedef logic [LIT_W-1:0]          lit_t;
  typedef logic [CLA_LITS*LIT_W-1:0] cla_t;
endpackage

module clause_loader
  import clause_loader_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              go_i,
  input  logic [ADDR_W:0]   num_cla_i,
  input  logic [ADDR_W:0]   num_uc_i,
  input  logic              hold_i,
  output logic              cla_mem_rd_o,
  output logic [ADDR_W-1:0] cla_mem_addr_o,
  input  cla_t              cla_mem_rdata_i,
  output logic              uc_mem_rd_o,
  output logic [ADDR_W-1:0] uc_mem_addr_o,
  input  lit_t              uc_mem_rdata_i,
  output logic              mem2carb_start_o,
  output cla_t              mem2carb_clause_o,
  output logic              mem2carb_uc_valid_o,
  output lit_t              mem2carb_uc_o,
  output logic              mem2carb_finish_o,
  input  logic              carb_empty_i,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [2:0] {S_IDLE, S_CLA, S_UC, S_FIN, S_WAIT, S_DONE} state_t;

  localparam logic [ADDR_W:0]   MAX_CNT  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   numCla_q, numCla_d;
  logic [ADDR_W:0]   numUc_q, numUc_d;
  logic [ADDR_W-1:0] claCnt_q, claCnt_d;
  logic [ADDR_W-1:0] ucCnt_q, ucCnt_d;
  logic              start_q, ucValid_q, finish_q;
  logic              claRd, ucRd;
  logic              lastCla, lastUc;

  function automatic logic [ADDR_W:0] clampCnt(input logic [ADDR_W:0] n);
    return (n > MAX_CNT) ? MAX_CNT : n;
  endfunction

  assign lastCla = ({1'b0, claCnt_q} == (numCla_q - CNT_ONE));
  assign lastUc  = ({1'b0, ucCnt_q} == (numUc_q - CNT_ONE));

  // Counters hold at the final address instead of wrapping past it.
  always_comb begin
    state_d  = state_q;
    numCla_d = numCla_q;
    numUc_d  = numUc_q;
    claCnt_d = claCnt_q;
    ucCnt_d  = ucCnt_q;
    claRd    = 1'b0;
    ucRd     = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go_i) begin
          numCla_d = clampCnt(num_cla_i);
          numUc_d  = clampCnt(num_uc_i);
          claCnt_d = '0;
          ucCnt_d  = '0;
          if (numCla_d != '0)     state_d = S_CLA;
          else if (numUc_d != '0) state_d = S_UC;
          else                    state_d = S_FIN;
        end
      end
      S_CLA: begin
        if (!hold_i) begin
          claRd = 1'b1;
          if (lastCla) state_d = (numUc_q == '0) ? S_FIN : S_UC;
          else         claCnt_d = claCnt_q + ADDR_ONE;
        end
      end
      S_UC: begin
        if (!hold_i) begin
          ucRd = 1'b1;
          if (lastUc) state_d = S_FIN;
          else        ucCnt_d = ucCnt_q + ADDR_ONE;
        end
      end
      S_FIN: state_d = S_WAIT;
      // carb_empty is ignored in the finish-pulse cycle itself.
      S_WAIT: begin
        if (carb_empty_i && !finish_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      numCla_q  <= '0;
      numUc_q   <= '0;
      claCnt_q  <= '0;
      ucCnt_q   <= '0;
      start_q   <= 1'b0;
      ucValid_q <= 1'b0;
      finish_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      numCla_q  <= numCla_d;
      numUc_q   <= numUc_d;
      claCnt_q  <= claCnt_d;
      ucCnt_q   <= ucCnt_d;
      start_q   <= claRd;
      ucValid_q <= ucRd;
      finish_q  <= (state_q == S_FIN);
    end
  end

  assign cla_mem_rd_o        = claRd;
  assign cla_mem_addr_o      = claCnt_q;
  assign uc_mem_rd_o         = ucRd;
  assign uc_mem_addr_o       = ucCnt_q;
  assign mem2carb_start_o    = start_q;
  assign mem2carb_clause_o   = cla_mem_rdata_i;
  assign mem2carb_uc_valid_o = ucValid_q;
  assign mem2carb_uc_o       = uc_mem_rdata_i;
  assign mem2carb_finish_o   = finish_q;
  assign busy_o              = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o              = (state_q == S_DONE);

endmodule

// File: tb/tb_clause_loader.sv
// Directed bench for clause_loader: behavioural 1-cycle-latency memories and
// cycle-by-cycle expectations derived by hand from the loader's timing.

module tb_clause_loader;
  import clause_loader_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              go;
  logic [ADDR_W:0]   numCla;
  logic [ADDR_W:0]   numUc;
  logic              hold;
  logic              claRd;
  logic [ADDR_W-1:0] claAddr;
  cla_t              claRdata;
  logic              ucRd;
  logic [ADDR_W-1:0] ucAddr;
  lit_t              ucRdata;
  logic              start;
  cla_t              clause;
  logic              ucValid;
  lit_t              uc;
  logic              finish;
  logic              carbEmpty;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  cla_t claMem [DEPTH];
  lit_t ucMem  [DEPTH];

  clause_loader #(.ADDR_W(ADDR_W)) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .go_i               (go),
    .num_cla_i          (numCla),
    .num_uc_i           (numUc),
    .hold_i             (hold),
    .cla_mem_rd_o       (claRd),
    .cla_mem_addr_o     (claAddr),
    .cla_mem_rdata_i    (claRdata),
    .uc_mem_rd_o        (ucRd),
    .uc_mem_addr_o      (ucAddr),
    .uc_mem_rdata_i     (ucRdata),
    .mem2carb_start_o   (start),
    .mem2carb_clause_o  (clause),
    .mem2carb_uc_valid_o(ucValid),
    .mem2carb_uc_o      (uc),
    .mem2carb_finish_o  (finish),
    .carb_empty_i       (carbEmpty),
    .busy_o             (busy),
    .done_o             (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (claRd) claRdata <= claMem[claAddr];
    if (ucRd)  ucRdata  <= ucMem[ucAddr];
  end

  function automatic cla_t claPat(int i);
    return {16'hA000 + 16'(i), 16'h5000 + 16'(i), 16'h0F0F ^ 16'(i)};
  endfunction

  function automatic lit_t ucPat(int i);
    return 16'hB000 + 16'(i);
  endfunction

  task automatic applyStimulus(input logic goV, input int nCla, input int nUc,
                               input logic holdV, input logic emptyV);
    go        = goV;
    numCla    = (ADDR_W+1)'(nCla);
    numUc     = (ADDR_W+1)'(nUc);
    hold      = holdV;
    carbEmpty = emptyV;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int starts, ucvs, fins, finCycle, rds, lastAddr, orderErr;
    logic finSeen;

    for (int i = 0; i < DEPTH; i++) begin
      claMem[i] = claPat(i);
      ucMem[i]  = ucPat(i);
    end
    claRdata = '0;
    ucRdata  = '0;
    rst = 1'b1;
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0);
    nextCycle();
    nextCycle();
    rst = 1'b0;

    @(negedge clk);
    checkOutput("reset cla_rd", 64'(claRd), 64'd0);
    checkOutput("reset uc_rd", 64'(ucRd), 64'd0);
    checkOutput("reset start", 64'(start), 64'd0);
    checkOutput("reset uc_valid", 64'(ucValid), 64'd0);
    checkOutput("reset finish", 64'(finish), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    nextCycle();

    // Run 1: N=4, M=2, no stalls; carb_empty from cycle 9.
    for (int c = 0; c <= 10; c++) begin
      applyStimulus(1'(c == 0), 4, 2, 1'b0, 1'(c >= 9));
      @(negedge clk);
      checkOutput("t1 cla_rd", 64'(claRd), 64'(c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) checkOutput("t1 cla_addr", 64'(claAddr), 64'(c - 1));
      checkOutput("t1 start", 64'(start), 64'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) checkOutput("t1 clause", 64'(clause), 64'(claPat(c - 2)));
      checkOutput("t1 uc_rd", 64'(ucRd), 64'(c >= 5 && c <= 6));
      if (c >= 5 && c <= 6) checkOutput("t1 uc_addr", 64'(ucAddr), 64'(c - 5));
      checkOutput("t1 uc_valid", 64'(ucValid), 64'(c >= 6 && c <= 7));
      if (c >= 6 && c <= 7) checkOutput("t1 uc", 64'(uc), 64'(ucPat(c - 6)));
      checkOutput("t1 finish", 64'(finish), 64'(c == 8));
      checkOutput("t1 busy", 64'(busy), 64'(c >= 1 && c <= 9));
      checkOutput("t1 done", 64'(done), 64'(c == 10));
      nextCycle();
    end

    // Run 2: N=4, M=0, hold during cycle 3; empty held high so done tests the ignore.
    starts = 0;
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(1'(c == 0), 4, 0, 1'(c == 3), 1'b1);
      @(negedge clk);
      if (start) starts++;
      checkOutput("t2 cla_rd", 64'(claRd), 64'(c == 1 || c == 2 || c == 4 || c == 5));
      if (c == 4 || c == 5) checkOutput("t2 cla_addr", 64'(claAddr), 64'(c - 2));
      checkOutput("t2 start", 64'(start), 64'(c == 2 || c == 3 || c == 5 || c == 6));
      if (c == 3) checkOutput("t2 clause1", 64'(clause), 64'(claPat(1)));
      checkOutput("t2 uc_valid", 64'(ucValid), 64'd0);
      checkOutput("t2 finish", 64'(finish), 64'(c == 7));
      if (c >= 1) checkOutput("t2 done", 64'(done), 64'(c == 9));
      nextCycle();
    end
    checkOutput("t2 start count", 64'(starts), 64'd4);

    // Run 3: N=0, M=0; empty during the finish cycle must be ignored.
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(1'(c == 0), 0, 0, 1'b0, 1'(c == 2 || c >= 5));
      @(negedge clk);
      checkOutput("t3 cla_rd", 64'(claRd), 64'd0);
      checkOutput("t3 uc_rd", 64'(ucRd), 64'd0);
      checkOutput("t3 finish", 64'(finish), 64'(c == 2));
      if (c >= 1) checkOutput("t3 busy", 64'(busy), 64'(c <= 5));
      if (c >= 1) checkOutput("t3 done", 64'(done), 64'(c == 6));
      nextCycle();
    end

    // Run 4: N=3, M=1 with extra go pulses (carrying 9/5) during CLA.
    starts = 0; ucvs = 0; finCycle = -1;
    for (int c = 0; c <= 8; c++) begin
      applyStimulus(1'(c == 0 || c == 2 || c == 3), (c == 0) ? 3 : 9, (c == 0) ? 1 : 5,
                    1'b0, 1'b1);
      @(negedge clk);
      if (start) starts++;
      if (ucValid) ucvs++;
      if (finish) finCycle = c;
      if (c == 8) checkOutput("t4 done", 64'(done), 64'd1);
      nextCycle();
    end
    checkOutput("t4 start count", 64'(starts), 64'd3);
    checkOutput("t4 uc_valid count", 64'(ucvs), 64'd1);
    checkOutput("t4 finish cycle", 64'(finCycle), 64'd6);

    // Run 5: N=8, M=1 aborted by reset in cycle 3.
    for (int c = 0; c <= 3; c++) begin
      applyStimulus(1'(c == 0), 8, 1, 1'b0, 1'b1);
      rst = 1'(c == 3);
      nextCycle();
    end
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t5 post-reset cla_rd", 64'(claRd), 64'd0);
    checkOutput("t5 post-reset cla_addr", 64'(claAddr), 64'd0);
    checkOutput("t5 post-reset start", 64'(start), 64'd0);
    checkOutput("t5 post-reset busy", 64'(busy), 64'd0);
    checkOutput("t5 post-reset done", 64'(done), 64'd0);
    fins = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (finish) fins++;
      nextCycle();
    end
    checkOutput("t5 no finish after abort", 64'(fins), 64'd0);
    for (int c = 0; c <= 6; c++) begin
      applyStimulus(1'(c == 0), 1, 1, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("t5 cla_rd", 64'(claRd), 64'(c == 1));
      checkOutput("t5 start", 64'(start), 64'(c == 2));
      if (c == 2) checkOutput("t5 clause", 64'(clause), 64'(claPat(0)));
      checkOutput("t5 uc_valid", 64'(ucValid), 64'(c == 3));
      if (c == 3) checkOutput("t5 uc", 64'(uc), 64'(ucPat(0)));
      checkOutput("t5 finish", 64'(finish), 64'(c == 4));
      if (c >= 1) checkOutput("t5 done", 64'(done), 64'(c == 6));
      nextCycle();
    end

    // Run 6: N = 2^ADDR_W + 1 is clamped to 2^ADDR_W.
    starts = 0; rds = 0; lastAddr = -1; orderErr = 0; finSeen = 1'b0; finCycle = -1;
    for (int c = 0; c < DEPTH + 60 && !finSeen; c++) begin
      applyStimulus(1'(c == 0), DEPTH + 1, 0, 1'b0, 1'b1);
      @(negedge clk);
      if (claRd) begin
        if (int'(claAddr) != rds) orderErr++;
        lastAddr = int'(claAddr);
        rds++;
      end
      if (start) begin
        if (clause !== claPat(starts)) orderErr++;
        starts++;
      end
      if (finish) begin
        finSeen  = 1'b1;
        finCycle = c;
      end
      nextCycle();
    end
    checkOutput("t6 finish seen", 64'(finSeen), 64'd1);
    checkOutput("t6 finish cycle", 64'(finCycle), 64'(DEPTH + 2));
    checkOutput("t6 read count", 64'(rds), 64'(DEPTH));
    checkOutput("t6 start count", 64'(starts), 64'(DEPTH));
    checkOutput("t6 last address", 64'(lastAddr), 64'(DEPTH - 1));
    checkOutput("t6 order errors", 64'(orderErr), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
